mod_adder_arb: RTL and testbench
================================

# mod_adder_arb

Round-robin arbiter and sequencer that shares one combinational `mod_adder` datapath among `NREQ` requesters. Each requester presents an operand pair under a valid/ready handshake. One winner per cycle is issued through the modular adder against the shared modulus `iQ`. The result is captured in a single-entry output register, tagged with the winner's index, and returned under a valid/ready handshake. The block sits between the NTT/poly-arith lane controllers and the single shared modular adder.

## Interface
- `NREQ`, default 4: number of requesters, 2..16.
- `BW`, default `` `BITWIDTH ``: operand/modulus width.
- `IDW`, default `$clog2(NREQ)`: width of the requester ID.

Ports:
- `iClk` in 1: clock. Single clock domain.
- `iRstN` in 1: reset, synchronous, active-low.
- `iEn` in 1: global enable. Low: no grants issued, output register holds.
- `iClr` in 1: synchronous clear. Same effect as reset on state; takes priority over `iEn`.
- `iQ` in BW: shared modulus. Sampled at accept.
- `iReqValid` in NREQ: per-requester request valid.
- `oReqReady` out NREQ: per-requester grant. One-hot or zero.
- `iReqData0` in NREQ*BW: operand A. Requester i occupies `[i*BW +: BW]`.
- `iReqData1` in NREQ*BW: operand B, same packing.
- `oRespValid` out 1: result available.
- `iRespReady` in 1: downstream accepts the result.
- `oRespId` out IDW: index of the requester that produced the result.
- `oRespData` out BW: `(A+B) mod iQ`.

## Operation
- Datapath: one `mod_adder` instance.
  - Sum is formed at BW+1 bits. If `sum >= iQ`, result is `sum - iQ`; otherwise result is `sum`.
  - The result is exact only for `A < iQ` and `B < iQ`. Other operands get the single conditional subtract, with no further correction.
  - `iQ = 0` passes `A+B` truncated to BW.
- FSM, 2 states:
  - EMPTY: `oRespValid = 0`.
  - FULL: `oRespValid = 1`.
- `canAccept = iEn & ~iClr & (EMPTY | (FULL & iRespReady))`.
- Grant:
  - If `canAccept`, `oReqReady` is one-hot on the first asserted `iReqValid` at or after `rrPtr`, searching upward with wrap.
  - Otherwise `oReqReady = 0`.
  - `oReqReady` is combinational from `iReqValid`, `rrPtr` and state. It never depends on requesters sampling it.
- Accept (`|(iReqValid & oReqReady)`):
  - Register `oRespData` ← adder result and `oRespId` ← winner index.
  - Go to (or stay in) FULL.
  - `rrPtr` ← winner+1, wrapping `NREQ-1` → 0.
- Drain without accept (`FULL & iRespReady`, no grant): go to EMPTY. Data and ID registers hold their last values.
- Simultaneous drain and accept: the new result replaces the old one in the same edge. `oRespValid` stays 1, giving full throughput.
- A requester dropping `iReqValid` before it is granted is legal. No grant is issued to a requester whose valid is low.
- `iQ` or operands changing while FULL: the held result is unaffected.

## Timing
- Reset (`iRstN` low at a rising edge) and `iClr`:
  - `oRespValid` = 0, `oRespId` = 0, `oRespData` = 0, `rrPtr` = 0, state EMPTY.
  - `oReqReady` = 0 throughout the reset/clear cycle.
- Latency: accept at edge N gives `oRespValid` and data visible after edge N, i.e. 1 cycle.
- Throughput: 1 result per cycle while `iRespReady` is high.
- Backpressure: FULL with `iRespReady` low → `oReqReady = 0` until drained. `oRespValid`, `oRespId` and `oRespData` stay stable while `oRespValid & ~iRespReady`.
- Reset mid-operation: a pending result is discarded. Requesters must re-present.
- `iEn` low: state, output registers and `rrPtr` are frozen, and `oRespValid` holds. Draining is also blocked: an `iRespReady` pulse is ignored while `iEn` is low.

## Configuration
- `MOD_ADDER_ARB_RR_EN`:
  - Defined: round-robin arbitration as above.
  - Undefined: fixed priority, lowest asserted index wins. `rrPtr` is removed, constant 0.

## Test plan
- Reset: hold `iRstN` low 2 cycles with all `iReqValid` high → `oReqReady` = 0, `oRespValid` = 0, `oRespId` = 0, `oRespData` = 0.
- Single request, BW = 8: req0 A = 10, B = 20; sweep `iQ` 23..32 one cycle each, `iRespReady` = 1 → `oRespData` = 7,6,5,4,3,2,1,0,30,30 one cycle after each accept, `oRespId` = 0.
- Round robin (RR_EN), all 4 valid continuously, `iRespReady` = 1 → grants 0,1,2,3,0,… on consecutive cycles. Without the macro → grant 0 every cycle.
- Backpressure: req1 A = 5, B = 6, `iQ` = 7; hold `iRespReady` = 0 for 3 cycles → `oRespData` = 4 and `oRespId` = 1 stable, `oReqReady` = 0; release → drained, next grant issued the same cycle.
- Boundary: A = B = 255, `iQ` = 255 (BW = 8) → 510 ≥ 255, result 255. A = 254, B = 254, `iQ` = 255 → 253. Neither case overflows.
- Clear mid-stream: FULL with `iRespReady` = 0, pulse `iClr` → next cycle `oRespValid` = 0, `rrPtr` = 0, and the first grant goes to the lowest valid index.

Source files
------------

// File: rtl/mod_adder_arb.sv
// mod_adder_arb: shares one combinational modular adder among NREQ
// requesters and returns each (A+B) mod iQ through a one-entry output register.
//
// Ports:
//   iClk, iRstN     clock, synchronous active-low reset
//   iEn             global enable (low freezes all state, including drain)
//   iClr            synchronous clear (same effect as reset, beats iEn)
//   iQ              shared modulus, sampled at accept
//   iReqValid       per-requester request valid
//   oReqReady       per-requester grant, one-hot or zero
//   iReqData0/1     packed operands A/B, requester i at [i*BW +: BW]
//   oRespValid      result held in the output register
//   iRespReady      downstream takes the result
//   oRespId         index of the requester that produced the result
//   oRespData       (A+B) mod iQ
//
// Build option: define MOD_ADDER_ARB_RR_EN for round-robin arbitration;
// without it the lowest asserted index always wins.

`ifndef BITWIDTH
`define BITWIDTH 8
`endif

module mod_adder #(
  parameter int BW = 8
) (
  input  logic [BW-1:0] a_i,
  input  logic [BW-1:0] b_i,
  input  logic [BW-1:0] q_i,
  output logic [BW-1:0] sum_o
);

  logic [BW:0] sum_w;
  logic [BW:0] q_w;

  assign sum_w = {1'b0, a_i} + {1'b0, b_i};
  assign q_w   = {1'b0, q_i};

  // One conditional subtract only: exact when both operands are below q.
  // q = 0 always takes the subtract branch, yielding the truncated sum.
  assign sum_o = (sum_w >= q_w) ? BW'(sum_w - q_w)
                                : BW'(sum_w);

endmodule

module mod_adder_arb #(
  parameter int NREQ = 4,
  parameter int BW   = `BITWIDTH,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic               iClk,
  input  logic               iRstN,
  input  logic               iEn,
  input  logic               iClr,
  input  logic [BW-1:0]      iQ,
  input  logic [NREQ-1:0]    iReqValid,
  output logic [NREQ-1:0]    oReqReady,
  input  logic [NREQ*BW-1:0] iReqData0,
  input  logic [NREQ*BW-1:0] iReqData1,
  output logic               oRespValid,
  input  logic               iRespReady,
  output logic [IDW-1:0]     oRespId,
  output logic [BW-1:0]      oRespData
);

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  logic           state_q, state_d;
  logic [IDW-1:0] id_q, id_d;
  logic [BW-1:0]  data_q, data_d;
  logic [IDW-1:0] ptr;

`ifdef MOD_ADDER_ARB_RR_EN
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

  assign ptr = rr_ptr_q;
`else
  assign ptr = '0;
`endif

  // First asserted valid at or after p, searching upward with wrap.
  // Scanning downward lets the lowest offset overwrite the result last.
  // MSB of the return value flags that some requester was found.
  function automatic logic [IDW:0] pick(
    input logic [NREQ-1:0] v,
    input logic [IDW-1:0]  p
  );
    logic [IDW:0] r;
    int           j;
    r = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(p) + k;
      if (j >= NREQ) begin
        j = j - NREQ;
      end
      if (v[j[IDW-1:0]]) begin
        r = {1'b1, j[IDW-1:0]};
      end
    end
    return r;
  endfunction

  logic [IDW:0]   pick_w;
  logic           hit_w;
  logic [IDW-1:0] win_w;
  logic           can_accept;
  logic           accept;
  logic [BW-1:0]  a_sel;
  logic [BW-1:0]  b_sel;
  logic [BW-1:0]  sum_w;

  assign pick_w = pick(iReqValid, ptr);
  assign hit_w  = pick_w[IDW];
  assign win_w  = pick_w[IDW-1:0];

  // iRstN is folded in so no grant leaks out during a reset cycle.
  assign can_accept = iRstN & iEn & ~iClr &
                      ((state_q == ST_EMPTY) | iRespReady);

  assign accept = can_accept & hit_w;

  always_comb begin
    oReqReady = '0;
    if (accept) begin
      oReqReady[win_w] = 1'b1;
    end
  end

  assign a_sel = iReqData0[int'(win_w)*BW +: BW];
  assign b_sel = iReqData1[int'(win_w)*BW +: BW];

  mod_adder #(
    .BW (BW)
  ) u_mod_adder (
    .a_i   (a_sel),
    .b_i   (b_sel),
    .q_i   (iQ),
    .sum_o (sum_w)
  );

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    data_d  = data_q;
`ifdef MOD_ADDER_ARB_RR_EN
    rr_ptr_d = rr_ptr_q;
`endif
    if (iEn) begin
      if (accept) begin
        // Covers a same-edge drain as well: new result replaces old.
        state_d = ST_FULL;
        id_d    = win_w;
        data_d  = sum_w;
`ifdef MOD_ADDER_ARB_RR_EN
        rr_ptr_d = (win_w == LAST_ID) ? '0 : win_w + 1'b1;
`endif
      end else if ((state_q == ST_FULL) && iRespReady) begin
        // Data and ID deliberately hold their last values.
        state_d = ST_EMPTY;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRstN || iClr) begin
      state_q <= ST_EMPTY;
      id_q    <= '0;
      data_q  <= '0;
`ifdef MOD_ADDER_ARB_RR_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      data_q  <= data_d;
`ifdef MOD_ADDER_ARB_RR_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  assign oRespValid = (state_q == ST_FULL);
  assign oRespId    = id_q;
  assign oRespData  = data_q;

endmodule

// File: tb/tb_mod_adder_arb.sv
// tb_mod_adder_arb: table vectors plus a cycle model and response queue
// for the shared modular-adder arbiter (NREQ = 4, BW = 8).

module tb_mod_adder_arb;

  localparam int NREQ = 4;
  localparam int BW   = 8;
  localparam int IDW  = 2;

  logic             iClk = 1'b0;
  logic             iRstN;
  logic             iEn;
  logic             iClr;
  logic [BW-1:0]    iQ;
  logic [NREQ-1:0]  iReqValid;
  logic [NREQ-1:0]  oReqReady;
  logic [NREQ*BW-1:0] iReqData0;
  logic [NREQ*BW-1:0] iReqData1;
  logic             oRespValid;
  logic             iRespReady;
  logic [IDW-1:0]   oRespId;
  logic [BW-1:0]    oRespData;

  always #5 iClk = ~iClk;

  mod_adder_arb #(
    .NREQ (NREQ),
    .BW   (BW),
    .IDW  (IDW)
  ) dut (
    .iClk       (iClk),
    .iRstN      (iRstN),
    .iEn        (iEn),
    .iClr       (iClr),
    .iQ         (iQ),
    .iReqValid  (iReqValid),
    .oReqReady  (oReqReady),
    .iReqData0  (iReqData0),
    .iReqData1  (iReqData1),
    .oRespValid (oRespValid),
    .iRespReady (iRespReady),
    .oRespId    (oRespId),
    .oRespData  (oRespData)
  );

  typedef struct {
    logic [7:0]  q;
    logic [7:0]  a;
    logic [7:0]  b;
    int unsigned id;
    logic [7:0]  res;
  } vec_t;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } rsp_t;

  vec_t tbl [12];
  rsp_t sb [$];
  rsp_t last;
  logic m_full;
  logic [1:0] m_ptr;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] modadd(input logic [7:0] a,
                                        input logic [7:0] b,
                                        input logic [7:0] q);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, q}) s = s - {1'b0, q};
    return s[7:0];
  endfunction

  function automatic logic [7:0] opnd(input logic [31:0] d, input int i);
    return d[i*8 +: 8];
  endfunction

  // Called just after a negedge with inputs set. Checks the DUT against
  // the model, then advances the model across the next rising edge.
  // ovr >= 0 supplies the expected result from a vector table.
  task automatic tick(input int ovr);
    logic [3:0] eg;
    int   wi;
    bit   found;
    bit   can;
    bit   acc;
    rsp_t e;
    rsp_t n;
    logic [7:0] r;
    #1;
    can = iRstN && iEn && !iClr && (!m_full || iRespReady);
    found = 0;
    wi = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int j;
      j = (int'(m_ptr) + k) % NREQ;
      if (iReqValid[j]) begin
        found = 1;
        wi = j;
      end
    end
    eg = '0;
    acc = can && found;
    if (acc) eg[wi] = 1'b1;
    chk("grant", oReqReady, eg);
    chk("resp_valid", oRespValid, m_full);
    e = (m_full && sb.size() > 0) ? sb[0] : last;
    chk("resp_id", oRespId, e.id);
    chk("resp_data", oRespData, e.data);
    r = (ovr >= 0) ? 8'(ovr)
                   : modadd(opnd(iReqData0, wi), opnd(iReqData1, wi), iQ);
    @(posedge iClk);
    if (!iRstN || iClr) begin
      m_full = 0;
      m_ptr = 0;
      sb.delete();
      last = '0;
    end else if (iEn) begin
      if (m_full && iRespReady) begin
        last = sb.pop_front();
        m_full = 0;
      end
      if (acc) begin
        n.id = 2'(wi);
        n.data = r;
        sb.push_back(n);
        m_full = 1;
`ifdef MOD_ADDER_ARB_RR_EN
        m_ptr = 2'((wi + 1) % NREQ);
`endif
      end
    end
    @(negedge iClk);
  endtask

  initial begin
    iRstN = 1'b0;
    iEn = 1'b1;
    iClr = 1'b0;
    iQ = '0;
    iReqValid = 4'hF;
    iReqData0 = '0;
    iReqData1 = '0;
    iRespReady = 1'b1;
    m_full = 0;
    m_ptr = 0;
    last = '0;

    for (int i = 0; i < 10; i++) begin
      tbl[i].q = 8'(23 + i);
      tbl[i].a = 8'd10;
      tbl[i].b = 8'd20;
      tbl[i].id = 0;
    end
    tbl[0].res = 8'd7;
    tbl[1].res = 8'd6;
    tbl[2].res = 8'd5;
    tbl[3].res = 8'd4;
    tbl[4].res = 8'd3;
    tbl[5].res = 8'd2;
    tbl[6].res = 8'd1;
    tbl[7].res = 8'd0;
    tbl[8].res = 8'd30;
    tbl[9].res = 8'd30;
    tbl[10] = '{q: 8'd255, a: 8'd255, b: 8'd255, id: 2, res: 8'd255};
    tbl[11] = '{q: 8'd255, a: 8'd254, b: 8'd254, id: 3, res: 8'd253};

    // reset held with every request asserted
    @(posedge iClk);
    @(negedge iClk);
    tick(-1);
    tick(-1);
    iRstN = 1'b1;

    // single-request sweep and overflow boundaries
    for (int i = 0; i < 12; i++) begin
      iReqValid = 4'b0001 << tbl[i].id;
      iQ = tbl[i].q;
      iReqData0[tbl[i].id*8 +: 8] = tbl[i].a;
      iReqData1[tbl[i].id*8 +: 8] = tbl[i].b;
      tick(int'(tbl[i].res));
    end
    iReqValid = '0;
    tick(-1);

    // arbitration sequence starting from a cleared pointer
    iClr = 1'b1;
    tick(-1);
    iClr = 1'b0;
    iQ = 8'd100;
    for (int i = 0; i < NREQ; i++) begin
      iReqData0[i*8 +: 8] = 8'(i * 20 + 3);
      iReqData1[i*8 +: 8] = 8'(i * 30 + 7);
    end
    iReqValid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1;
`ifdef MOD_ADDER_ARB_RR_EN
      chk("rr_seq", oReqReady, 4'b0001 << (k % 4));
`else
      chk("fixed_seq", oReqReady, 4'b0001);
`endif
      tick(-1);
    end

    // backpressure: held result stable while operands and iQ change
    iReqValid = '0;
    tick(-1);
    iReqValid = 4'b0010;
    iReqData0[15:8] = 8'd5;
    iReqData1[15:8] = 8'd6;
    iQ = 8'd7;
    tick(4);
    iRespReady = 1'b0;
    iReqValid = 4'hF;
    iQ = 8'd3;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_data", oRespData, 8'd4);
      chk("bp_id", oRespId, 2'd1);
      tick(-1);
    end
    iRespReady = 1'b1;
    tick(-1);

    // enable low freezes state and ignores drain
    iEn = 1'b0;
    tick(-1);
    tick(-1);
    iEn = 1'b1;

    // clear while full and stalled
    iRespReady = 1'b0;
    tick(-1);
    iClr = 1'b1;
    tick(-1);
    iClr = 1'b0;
    iReqValid = 4'b1010;
    iRespReady = 1'b1;
    #1;
    chk("clr_first", oReqReady, 4'b0010);
    tick(-1);

    // reset mid-operation
    iRespReady = 1'b0;
    tick(-1);
    iRstN = 1'b0;
    tick(-1);
    iRstN = 1'b1;
    tick(-1);

    // random traffic
    for (int k = 0; k < 300; k++) begin
      iRstN = ($urandom_range(0, 49) != 0);
      iEn = ($urandom_range(0, 7) != 0);
      iClr = ($urandom_range(0, 59) == 0);
      iReqValid = 4'($urandom);
      iRespReady = ($urandom_range(0, 3) != 0);
      iQ = 8'($urandom);
      iReqData0 = $urandom;
      iReqData1 = $urandom;
      tick(-1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
